// File: rtl/tail_light_pkg.sv
// rtl/tail_light_pkg.sv - shared mode encodings for the tail light controller
//
// Purpose: mode constants shared by the controller and anything observing
//          its mode output.
// Contents: mode_t enum (IDLE, LEFT, RIGHT, HAZARD).
package tail_light_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'b00,
    MODE_LEFT   = 2'b01,
    MODE_RIGHT  = 2'b10,
    MODE_HAZARD = 2'b11
  } mode_t;

endpackage

// File: rtl/tail_light_tick.sv
// rtl/tail_light_tick.sv - free-running step timer producing one tick per step
//
// Purpose: counts 0..STEP_CYCLES-1 while enabled and flags the last count.
// Ports:
//   clk    - system clock
//   rst    - synchronous active-high reset
//   clear  - synchronous clear to 0 (has priority over counting)
//   enable - count while high; held at 0 while low
//   tick   - high during the cycle the count equals STEP_CYCLES-1
module tail_light_tick #(
  parameter int STEP_CYCLES = 12500000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(STEP_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

  if (STEP_CYCLES < 2 || STEP_CYCLES > (1 << 24)) begin : g_bad_step
    $error("tail_light_tick: STEP_CYCLES out of range 2..2^24");
  end

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + CW'(1);
    end else begin
      count <= '0;
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/tail_light_ctrl.sv
// rtl/tail_light_ctrl.sv - sequential turn / hazard / brake tail light controller
//
// Purpose: decodes indicator, hazard and brake requests into a mode and
//          drives the sequenced lamp patterns for both sides.
// Ports:
//   clk        - system clock
//   rst        - synchronous active-high reset
//   brake      - brake pedal (level)
//   turn_left  - left indicator request (level)
//   turn_right - right indicator request (level)
//   hazard     - hazard switch (level)
//   lamp_l     - left lamps, bit 0 innermost, registered
//   lamp_r     - right lamps, bit 0 innermost, registered
//   mode       - current mode, registered
module tail_light_ctrl
  import tail_light_pkg::*;
#(
  parameter int LAMPS       = 3,
  parameter int STEP_CYCLES = 12500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             brake,
  input  logic             turn_left,
  input  logic             turn_right,
  input  logic             hazard,
  output logic [LAMPS-1:0] lamp_l,
  output logic [LAMPS-1:0] lamp_r,
  output logic [1:0]       mode
);

  localparam int PW = $clog2(LAMPS + 1);
  localparam logic [PW-1:0] PHASE_MAX = PW'(LAMPS);
  localparam logic [PW-1:0] PHASE_ONE = PW'(1);

  if (LAMPS < 1 || LAMPS > 8) begin : g_bad_lamps
    $error("tail_light_ctrl: LAMPS out of range 1..8");
  end

  mode_t            state, state_nx;
  logic [PW-1:0]    phase, phase_nx;
  logic [LAMPS-1:0] lamp_l_nx, lamp_r_nx, turn_pat, brake_pat;
  logic             tick;
  logic             mode_change;

  // Mode decode is purely combinational so outputs follow inputs at the
  // same edge they are sampled.
  always_comb begin
    state_nx = MODE_IDLE;
    if (hazard || (turn_left && turn_right)) state_nx = MODE_HAZARD;
    else if (turn_left)                      state_nx = MODE_LEFT;
    else if (turn_right)                     state_nx = MODE_RIGHT;
  end

  assign mode_change = (state_nx != state);

  tail_light_tick #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clear  (mode_change),
    .enable (state != MODE_IDLE),
    .tick   (tick)
  );

  // Hazard reuses the phase counter's value 1/0 as its on/off phase.
  always_comb begin
    phase_nx = phase;
    if (mode_change) begin
      phase_nx = PHASE_ONE;
    end else if (tick) begin
      case (state)
        MODE_HAZARD:           phase_nx = (phase == PHASE_ONE) ? '0 : PHASE_ONE;
        MODE_LEFT, MODE_RIGHT: phase_nx = (phase == PHASE_MAX) ? '0 : phase + PHASE_ONE;
        default:               phase_nx = phase;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < LAMPS; i++) begin
      turn_pat[i] = (PW'(i) < phase_nx);
    end
    brake_pat = brake ? '1 : '0;
    lamp_l_nx = '0;
    lamp_r_nx = '0;
    case (state_nx)
      MODE_LEFT: begin
        lamp_l_nx = turn_pat;
        lamp_r_nx = brake_pat;
      end
      MODE_RIGHT: begin
        lamp_l_nx = brake_pat;
        lamp_r_nx = turn_pat;
      end
      MODE_HAZARD: begin
        lamp_l_nx = (phase_nx == PHASE_ONE) ? '1 : '0;
        lamp_r_nx = (phase_nx == PHASE_ONE) ? '1 : '0;
      end
      default: begin
        lamp_l_nx = brake_pat;
        lamp_r_nx = brake_pat;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= MODE_IDLE;
      phase  <= '0;
      lamp_l <= '0;
      lamp_r <= '0;
    end else begin
      state  <= state_nx;
      phase  <= phase_nx;
      lamp_l <= lamp_l_nx;
      lamp_r <= lamp_r_nx;
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_tail_light_ctrl.sv
// tb/tb_tail_light_ctrl.sv - directed self-checking bench for tail_light_ctrl
module tb_tail_light_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       brake = 1'b0;
  logic       turn_left = 1'b0;
  logic       turn_right = 1'b0;
  logic       hazard = 1'b0;
  logic [2:0] lamp_l, lamp_r;
  logic [1:0] mode;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;

  tail_light_ctrl #(
    .LAMPS       (3),
    .STEP_CYCLES (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .brake      (brake),
    .turn_left  (turn_left),
    .turn_right (turn_right),
    .hazard     (hazard),
    .lamp_l     (lamp_l),
    .lamp_r     (lamp_r),
    .mode       (mode)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic clk_edge();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic go_to(input int k);
    while (edge_n < k) clk_edge();
  endtask

  task automatic check_out(input string tag, input logic [2:0] l, input logic [2:0] r,
                           input logic [1:0] m);
    check({tag, ".lamp_l"}, 32'(lamp_l), 32'(l));
    check({tag, ".lamp_r"}, 32'(lamp_r), 32'(r));
    check({tag, ".mode"},   32'(mode),   32'(m));
  endtask

  // Reset edge is edge 0; other inputs are held active to show they are ignored.
  task automatic do_reset(input string tag);
    rst = 1'b1; hazard = 1'b1; brake = 1'b1; turn_left = 1'b1; turn_right = 1'b0;
    @(posedge clk);
    #1;
    check_out({tag, ".rst"}, 3'b000, 3'b000, 2'b00);
    edge_n = 0;
    rst = 1'b0; hazard = 1'b0; brake = 1'b0; turn_left = 1'b0; turn_right = 1'b0;
  endtask

  initial begin
    // Left sequence
    do_reset("left");
    turn_left = 1'b1;
    go_to(1);  check_out("left@1",  3'b001, 3'b000, 2'b01);
    go_to(4);  check_out("left@4",  3'b001, 3'b000, 2'b01);
    go_to(5);  check_out("left@5",  3'b011, 3'b000, 2'b01);
    go_to(9);  check_out("left@9",  3'b111, 3'b000, 2'b01);
    go_to(13); check_out("left@13", 3'b000, 3'b000, 2'b01);
    go_to(17); check_out("left@17", 3'b001, 3'b000, 2'b01);

    // Brake during right turn
    do_reset("rbrk");
    turn_right = 1'b1; brake = 1'b1;
    go_to(1); check_out("rbrk@1", 3'b111, 3'b001, 2'b10);
    go_to(5); check_out("rbrk@5", 3'b111, 3'b011, 2'b10);
    go_to(6);
    brake = 1'b0;
    go_to(7); check_out("rbrk@7", 3'b000, 3'b011, 2'b10);
    go_to(8); check_out("rbrk@8", 3'b000, 3'b011, 2'b10);
    go_to(9); check_out("rbrk@9", 3'b000, 3'b111, 2'b10);

    // Both indicators act as hazard; brake ignored
    do_reset("both");
    turn_left = 1'b1; turn_right = 1'b1; brake = 1'b1;
    go_to(1); check_out("both@1", 3'b111, 3'b111, 2'b11);
    go_to(4); check_out("both@4", 3'b111, 3'b111, 2'b11);
    go_to(5); check_out("both@5", 3'b000, 3'b000, 2'b11);
    go_to(9); check_out("both@9", 3'b111, 3'b111, 2'b11);

    // Mode change left -> right restarts timer and phase
    do_reset("chg");
    turn_left = 1'b1;
    go_to(5); check_out("chg@5", 3'b011, 3'b000, 2'b01);
    go_to(6);
    turn_left = 1'b0; turn_right = 1'b1;
    go_to(7);  check_out("chg@7",  3'b000, 3'b001, 2'b10);
    go_to(10); check_out("chg@10", 3'b000, 3'b001, 2'b10);
    go_to(11); check_out("chg@11", 3'b000, 3'b011, 2'b10);

    // Reset mid-hazard
    do_reset("hrst");
    hazard = 1'b1;
    go_to(1); check_out("hrst@1", 3'b111, 3'b111, 2'b11);
    go_to(5); check_out("hrst@5", 3'b000, 3'b000, 2'b11);
    rst = 1'b1;
    go_to(6); check_out("hrst@6", 3'b000, 3'b000, 2'b00);
    rst = 1'b0;
    go_to(7);  check_out("hrst@7",  3'b111, 3'b111, 2'b11);
    go_to(10); check_out("hrst@10", 3'b111, 3'b111, 2'b11);
    go_to(11); check_out("hrst@11", 3'b000, 3'b000, 2'b11);

    // Idle brake
    do_reset("ibrk");
    brake = 1'b1;
    go_to(1); check_out("ibrk@1", 3'b111, 3'b111, 2'b00);
    go_to(6); check_out("ibrk@6", 3'b111, 3'b111, 2'b00);
    brake = 1'b0;
    go_to(7); check_out("ibrk@7", 3'b000, 3'b000, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tail_light_ctrl.md
TAIL_LIGHT_CTRL -- requirements
Module: tail_light_ctrl

Interface
REQ-001 Parameter LAMPS, default 3, lamps per side; legal range 1..8.
REQ-002 Parameter STEP_CYCLES, default 12500000, clk cycles per sequence step; legal range 2..2^24.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 brake  input  1  brake pedal, level-sensitive.
REQ-006 turn_left  input  1  left indicator request, level-sensitive.
REQ-007 turn_right  input  1  right indicator request, level-sensitive.
REQ-008 hazard  input  1  hazard switch, level-sensitive.
REQ-009 lamp_l  output  LAMPS  left lamps; bit 0 is innermost; registered.
REQ-010 lamp_r  output  LAMPS  right lamps; bit 0 is innermost; registered.
REQ-011 mode  output  2  current mode: 00 IDLE, 01 LEFT, 10 RIGHT, 11 HAZARD; registered.

Function
REQ-012 The next mode SHALL be decoded from the inputs every cycle, evaluated in this order:
- hazard=1, or turn_left=1 and turn_right=1 -> HAZARD.
- turn_left=1 only -> LEFT.
- turn_right=1 only -> RIGHT.
- otherwise -> IDLE.
REQ-013 Latency: inputs sampled at edge k SHALL drive mode, lamp_l and lamp_r updated at the same edge k; there is no further delay.
REQ-014 Step timer: counts 0..STEP_CYCLES-1 in LEFT, RIGHT and HAZARD; a tick SHALL occur on the cycle the count equals STEP_CYCLES-1, and the count then wraps to 0.
REQ-015 In IDLE the step timer SHALL be held at 0.
REQ-016 On any mode change, the step timer SHALL be cleared to 0 and the phase SHALL be set to 1, at the same edge the new mode is registered.
REQ-017 Turn phase range and advance:
- Phase counter range is 0..LAMPS.
- Each tick in LEFT/RIGHT increments the phase.
- Phase LAMPS wraps to 0 on the following tick.
REQ-018 Turn pattern: the sequencing side SHALL show lamp bits [phase-1:0] set and all others clear; phase 0 shows all lamps off.
REQ-019 HAZARD phase: one bit; it SHALL be 1 on entry and toggle on each tick.
REQ-020 HAZARD lamps: lamp_l and lamp_r SHALL be all ones when the hazard phase is 1 and all zeros when it is 0.
REQ-021 Brake in LEFT/RIGHT: brake=1 SHALL force the non-sequencing side to all ones; brake=0 leaves that side all zeros.
REQ-022 Brake never alters the sequencing side.
REQ-023 Brake in IDLE: brake=1 SHALL drive both sides all ones; brake=0 drives both sides all zeros.
REQ-024 Brake in HAZARD SHALL have no effect on the lamps.
REQ-025 Brake changes alone SHALL NOT reset the step timer or the phase.
REQ-026 Widths:
- Step timer is $clog2(STEP_CYCLES) bits.
- Phase counter is $clog2(LAMPS+1) bits.
- All comparisons are unsigned; no overflow is permitted.

Reset
REQ-027 While rst=1 at an edge, the block SHALL set:
- mode=IDLE;
- lamp_l=0 and lamp_r=0;
- step timer=0;
- phase=0.
These values hold regardless of the other inputs.
REQ-028 Reset asserted mid-sequence SHALL abort the sequence at that edge.
REQ-029 The first edge with rst=0 SHALL decode the inputs per REQ-012.

Structure
REQ-030 The mode encodings (IDLE, LEFT, RIGHT, HAZARD) SHALL be constants in the shared package tail_light_pkg.
REQ-031 The step timer SHALL be a sub-module tail_light_tick (ports: clk, rst, clear, enable, tick), parametrised by STEP_CYCLES.
REQ-032 Illegal parameter values SHALL be rejected at elaboration.

Verification (LAMPS=3, STEP_CYCLES=4)
REQ-033 Left sequence: turn_left held from edge 1 -> lamp_l = 001@1, 011@5, 111@9, 000@13, 001@17; lamp_r=000; mode=01.
REQ-034 Brake during right turn: turn_right and brake held from edge 1 -> lamp_l=111 throughout; lamp_r = 001@1, 011@5; brake released at edge 7 -> lamp_l=000@7, lamp_r still 011@8.
REQ-035 Both indicators: turn_left and turn_right together -> mode=11; both sides 111@1, 000@5, 111@9; brake=1 changes nothing.
REQ-036 Mode change: LEFT at phase 2, then switch to turn_right at edge 7 -> lamp_r=001@7, 011@11; lamp_l=000@7.
REQ-037 Reset mid-sequence: rst pulsed at edge 6 during HAZARD -> all outputs 0@6; with hazard still high, both sides 111@7, 000@11.
REQ-038 Idle brake: brake only -> both sides 111, mode=00; brake released -> both sides 000 at the next edge.
